alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
//
// PURPOSE
// - Parametrised, pipelined successor to the processor's single-cycle-register ALU.
// - Adds a valid qualifier, configurable pipeline depth, logic/shift/unsigned ops and per-result status flags.
// - Sits between register-file read and write-back in each distributed-processor core.
// - Op codes 0-6 keep the existing encoding, so current instruction decode is unchanged.
//
// PARAMETERS
// - DATA_WIDTH   32  operand/result width (>=8)
// - PIPE_STAGES  2   total latency in cycles from in_valid to out_valid (>=1)
//
// PORTS
// - clk          in   1           core clock
// - rst          in   1           synchronous, active-high reset
// - in_valid     in   1           operands/ctrl valid this cycle
// - ctrl         in   4           op code (see BEHAVIOUR)
// - in0          in   DATA_WIDTH  operand A
// - in1          in   DATA_WIDTH  operand B
// - out_valid    out  1           result valid
// - out          out  DATA_WIDTH  result
// - flags        out  3           {oflow, neg, zero} of the result, aligned with out
// - clr_sticky   in   1           clears sticky_oflow
// - sticky_oflow out  1           latched signed-overflow indicator
//
// BEHAVIOUR
// - Op codes:
//   0 in0; 1 in0+in1; 2 in0-in1; 3 eq; 4 signed in0<in1; 5 signed in0>=in1; 6 in1;
//   7 and; 8 or; 9 xor; 10 shl; 11 shr logical; 12 shr arithmetic; 13 unsigned in0<in1;
//   14-15 result 0.
// - Compare ops (3,4,5,13) return bit0 = result, all other bits 0.
// - Shift amount = in1[$clog2(DATA_WIDTH)-1:0]; upper bits of in1 are ignored.
// - Add/sub wrap modulo 2^DATA_WIDTH, two's complement.
// - Signed compare uses sub sign XOR sub overflow, so it is correct across overflow.
// - Flags:
//   - oflow: set only on ops 1/2 when signed overflow occurs.
//   - neg: out[MSB].
//   - zero: out==0.
// - Pipeline:
//   - Stage 1 registers in0/in1/ctrl/in_valid unconditionally each cycle.
//   - The combinational result is computed from the stage-1 registers.
//   - PIPE_STAGES-1 further register stages carry {valid, out, flags}.
//   - out/flags reflect a transaction exactly PIPE_STAGES cycles after its in_valid.
// - No stall or backpressure: one op per cycle sustained. Back-to-back valids yield back-to-back out_valid.
// - Payload registers are not gated by valid. out may change while out_valid=0; consumers qualify on out_valid.
// - Reset:
//   - All valid bits, out, flags and sticky_oflow are 0 on the cycle after rst is high.
//   - A reset mid-stream drops all in-flight ops; no out_valid is emitted for them.
//   - Inputs presented during rst are discarded.
// - PIPE_STAGES=1: out is combinational from the stage-1 registers.
//
// CONFIGURATION
// - Macro ALU_STICKY_OFLOW_EN:
//   - Defined: sticky_oflow sets on any out_valid with flags[2]=1 and holds until clr_sticky or rst.
//     - Set and clear in the same cycle: set wins.
//   - Undefined: sticky_oflow is tied 0 and clr_sticky is ignored. Ports stay present so the interface is fixed.
//
// STRUCTURE
// - Package alu_pkg holds:
//   - localparam op codes: ALU_ID0, ALU_ADD, ALU_SUB, ALU_EQ, ALU_LT, ALU_GE, ALU_ID1, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_SRA, ALU_LTU
//   - ALU_CTRL_WIDTH=4
//   - flag bit indices FLAG_ZERO=0, FLAG_NEG=1, FLAG_OFLOW=2
// - Sub-module alu_pipe_stage: one {valid, data} register with synchronous reset. It is instantiated PIPE_STAGES-1 times via generate.
//
// TESTING
// - PIPE_STAGES=2, op 1, 0x7FFFFFFF+1 -> out=0x80000000, flags=3'b110, out_valid 2 cycles after in_valid.
// - Op 4 with in0=0x80000000, in1=1 -> out=1.
// - Op 5 with the same operands -> out=0.
// - Op 13 with the same operands -> out=0.
// - Op 12 with in0=0xF0000000, in1=0x24 (shift 4) -> out=0xFF000000.
// - Op 11 with the same operands -> out=0x0F000000.
// - 16 back-to-back valids with random ops vs model -> 16 consecutive out_valid, all match.
//   - Then sweep PIPE_STAGES in {1,3}.
// - Assert rst while 2 ops are in flight -> no out_valid for them.
//   - out=0, flags=0, sticky_oflow=0 next cycle.
// - With ALU_STICKY_OFLOW_EN:
//   - Op 2 with 0x80000000-1 -> sticky_oflow=1 and stays 1 through 5 further non-overflow ops.
//   - clr_sticky -> 0 next cycle.
//   - Without the macro, sticky_oflow stays 0 for the same stimulus.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, control width and flag bit positions shared by the ALU pipeline.
package alu_pkg;
  localparam int ALU_CTRL_WIDTH = 4;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ID0 = 4'd0;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = 4'd1;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = 4'd2;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_EQ  = 4'd3;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_LT  = 4'd4;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_GE  = 4'd5;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ID1 = 4'd6;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = 4'd7;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = 4'd8;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR = 4'd9;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SHL = 4'd10;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SHR = 4'd11;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA = 4'd12;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_LTU = 4'd13;
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_OFLOW = 2;
endpackage

// File: rtl/alu_pipe_stage.sv
// alu_pipe_stage: one {valid, data} pipeline register with synchronous reset.
module alu_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU with valid, status flags and optional sticky overflow.
// Define ALU_STICKY_OFLOW_EN to enable the sticky_oflow latch.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [ALU_CTRL_WIDTH-1:0] ctrl,
  input  logic [DATA_WIDTH-1:0]     in0,
  input  logic [DATA_WIDTH-1:0]     in1,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out,
  output logic [2:0]                flags,
  input  logic                      clr_sticky,
  output logic                      sticky_oflow
);
  localparam int SW = $clog2(DATA_WIDTH);
  localparam int PW = DATA_WIDTH + 3;
  localparam int M  = DATA_WIDTH - 1;
  logic                      valid_q, rst_q;
  logic [ALU_CTRL_WIDTH-1:0] ctrl_q;
  logic [DATA_WIDTH-1:0]     a_q, b_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rst_q   <= 1'b1;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_q <= in_valid;
      rst_q   <= 1'b0;
      ctrl_q  <= ctrl;
      a_q     <= in0;
      b_q     <= in1;
    end
  end
  logic [DATA_WIDTH-1:0] sum, diff, res;
  logic [SW-1:0]         sh;
  logic                  add_ov, sub_ov, lt, ovf;
  logic [2:0]            fl;
  assign sum    = a_q + b_q;
  assign diff   = a_q - b_q;
  assign sh     = b_q[SW-1:0];
  assign add_ov = (a_q[M] == b_q[M]) && (sum[M] != a_q[M]);
  assign sub_ov = (a_q[M] != b_q[M]) && (diff[M] != a_q[M]);
  assign lt     = diff[M] ^ sub_ov;
  assign ovf    = (ctrl_q == ALU_ADD && add_ov) || (ctrl_q == ALU_SUB && sub_ov);
  always_comb begin
    res = '0;
    case (ctrl_q)
      ALU_ID0: res = a_q;
      ALU_ADD: res = sum;
      ALU_SUB: res = diff;
      ALU_EQ:  res[0] = a_q == b_q;
      ALU_LT:  res[0] = lt;
      ALU_GE:  res[0] = !lt;
      ALU_ID1: res = b_q;
      ALU_AND: res = a_q & b_q;
      ALU_OR:  res = a_q | b_q;
      ALU_XOR: res = a_q ^ b_q;
      ALU_SHL: res = a_q << sh;
      ALU_SHR: res = a_q >> sh;
      ALU_SRA: res = $unsigned($signed(a_q) >>> sh);
      ALU_LTU: res[0] = a_q < b_q;
      default: res = '0;
    endcase
  end
  // Flags are held at 0 for the cycle after reset so a 1-stage pipe reports 0 too.
  always_comb begin
    fl = '0;
    fl[FLAG_OFLOW] = !rst_q && ovf;
    fl[FLAG_NEG]   = !rst_q && res[M];
    fl[FLAG_ZERO]  = !rst_q && (res == '0);
  end
  logic          v [PIPE_STAGES];
  logic [PW-1:0] d [PIPE_STAGES];
  assign v[0] = valid_q;
  assign d[0] = {fl, res};
  for (genvar i = 1; i < PIPE_STAGES; i++) begin : g_stage
    alu_pipe_stage #(.W(PW)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .valid_i(v[i-1]),
      .data_i (d[i-1]),
      .valid_o(v[i]),
      .data_o (d[i])
    );
  end
  assign out_valid    = v[PIPE_STAGES-1];
  assign {flags, out} = d[PIPE_STAGES-1];
`ifdef ALU_STICKY_OFLOW_EN
  logic sticky_q;
  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else if (out_valid && flags[FLAG_OFLOW]) sticky_q <= 1'b1;
    else if (clr_sticky) sticky_q <= 1'b0;
  end
  assign sticky_oflow = sticky_q;
`else
  assign sticky_oflow = clr_sticky & 1'b0;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table vectors, hand sequences and random ops on PIPE_STAGES 1/2/3 vs a reference model.
module tb_alu_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1, in_valid = 1'b0, clr_sticky = 1'b0;
  logic [3:0]  ctrl = '0;
  logic [31:0] in0 = '0, in1 = '0;
  logic        ov [3];
  logic [31:0] o  [3];
  logic [2:0]  f  [3];
  logic        st [3];
  int          pst [3] = '{1, 2, 3};
  int          nvec = 0, nmis = 0, n = 0;
  logic        hv [1024];
  logic        hr [1024];
  logic [34:0] hm [1024];
  logic        ev [3] = '{1'b0, 1'b0, 1'b0};
  logic [2:0]  ef [3] = '{3'b0, 3'b0, 3'b0};
  logic        es [3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  alu_pipe #(.DATA_WIDTH(32), .PIPE_STAGES(1)) u_p1 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .ctrl(ctrl), .in0(in0), .in1(in1), .out_valid(ov[0]), .out(o[0]), .flags(f[0]),
    .clr_sticky(clr_sticky), .sticky_oflow(st[0]));
  alu_pipe #(.DATA_WIDTH(32), .PIPE_STAGES(2)) u_p2 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .ctrl(ctrl), .in0(in0), .in1(in1), .out_valid(ov[1]), .out(o[1]), .flags(f[1]),
    .clr_sticky(clr_sticky), .sticky_oflow(st[1]));
  alu_pipe #(.DATA_WIDTH(32), .PIPE_STAGES(3)) u_p3 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .ctrl(ctrl), .in0(in0), .in1(in1), .out_valid(ov[2]), .out(o[2]), .flags(f[2]),
    .clr_sticky(clr_sticky), .sticky_oflow(st[2]));

  // Reference: signed arithmetic done in 64 bits, flags derived from the final value.
  function automatic logic [34:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    logic [31:0] r;
    logic ovf;
    logic [4:0] sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    ovf = 1'b0;
    r = '0;
    case (c)
      4'd0:  r = a;
      4'd1:  begin s = sa + sb; r = a + b; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2:  begin s = sa - sb; r = a - b; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd3:  r = {31'b0, a == b};
      4'd4:  r = {31'b0, sa < sb};
      4'd5:  r = {31'b0, sa >= sb};
      4'd6:  r = b;
      4'd7:  r = a & b;
      4'd8:  r = a | b;
      4'd9:  r = a ^ b;
      4'd10: r = a << sh;
      4'd11: r = a >> sh;
      4'd12: r = $unsigned($signed(a) >>> sh);
      4'd13: r = {31'b0, a < b};
      default: r = '0;
    endcase
    return {ovf, r[31], r == 32'd0, r};
  endfunction

  task automatic chk(input string nm, input int k, input logic [34:0] act, input logic [34:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s P=%0d cyc=%0d: got %h want %h", nm, pst[k], n, act, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic r, input logic clr);
    logic ns [3];
    int src;
    logic xv;
    logic [34:0] xm;
    in_valid = v; ctrl = c; in0 = a; in1 = b; rst = r; clr_sticky = clr;
    for (int k = 0; k < 3; k++) begin
`ifdef ALU_STICKY_OFLOW_EN
      ns[k] = r ? 1'b0 : (ev[k] && ef[k][2]) ? 1'b1 : clr ? 1'b0 : es[k];
`else
      ns[k] = 1'b0;
`endif
    end
    hv[n] = v; hr[n] = r; hm[n] = model(c, a, b);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      src = n - pst[k] + 1;
      xv = 1'b0;
      xm = '0;
      if (src >= 0) begin
        xv = hv[src];
        xm = hm[src];
        for (int j = src; j <= n; j++) if (hr[j]) xv = 1'b0;
      end
      chk("out_valid", k, 35'(ov[k]), 35'(xv));
      if (xv) begin
        chk("out", k, 35'(o[k]), 35'(xm[31:0]));
        chk("flags", k, 35'(f[k]), 35'(xm[34:32]));
      end
      if (r) begin
        chk("rst_out", k, 35'(o[k]), 35'd0);
        chk("rst_flags", k, 35'(f[k]), 35'd0);
      end
      chk("sticky", k, 35'(st[k]), 35'(ns[k]));
      ev[k] = xv;
      ef[k] = xv ? xm[34:32] : 3'b0;
      es[k] = ns[k];
    end
    n++;
  endtask

  function automatic logic [31:0] rnd();
    logic [31:0] edges [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h24};
    return ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
  endfunction

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a, b, eo;
    logic [2:0]  ef;
  } vec_t;
  vec_t tbl [14];

  initial begin
    tbl[0]  = '{4'd1,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'b110};
    tbl[1]  = '{4'd4,  32'h80000000, 32'h00000001, 32'h00000001, 3'b000};
    tbl[2]  = '{4'd5,  32'h80000000, 32'h00000001, 32'h00000000, 3'b001};
    tbl[3]  = '{4'd13, 32'h80000000, 32'h00000001, 32'h00000000, 3'b001};
    tbl[4]  = '{4'd12, 32'hF0000000, 32'h00000024, 32'hFF000000, 3'b010};
    tbl[5]  = '{4'd11, 32'hF0000000, 32'h00000024, 32'h0F000000, 3'b000};
    tbl[6]  = '{4'd2,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 3'b100};
    tbl[7]  = '{4'd7,  32'hF0F00000, 32'hFF00FF00, 32'hF0000000, 3'b010};
    tbl[8]  = '{4'd9,  32'hFFFF0000, 32'hFFFFFFFF, 32'h0000FFFF, 3'b000};
    tbl[9]  = '{4'd10, 32'h00000001, 32'h00000021, 32'h00000002, 3'b000};
    tbl[10] = '{4'd6,  32'h00001234, 32'hABCD0000, 32'hABCD0000, 3'b010};
    tbl[11] = '{4'd15, 32'h00000005, 32'h00000005, 32'h00000000, 3'b001};
    tbl[12] = '{4'd4,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 3'b001};
    tbl[13] = '{4'd3,  32'h00000005, 32'h00000005, 32'h00000001, 3'b000};
    repeat (2) cycle(1'b1, 4'd1, 32'h5, 32'h6, 1'b1, 1'b0);
    cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, tbl[i].c, tbl[i].a, tbl[i].b, 1'b0, 1'b0);
      cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b0);
      chk("tbl_valid", 1, 35'(ov[1]), 35'd1);
      chk("tbl_out", 1, 35'(o[1]), 35'(tbl[i].eo));
      chk("tbl_flags", 1, 35'(f[1]), 35'(tbl[i].ef));
    end
    cycle(1'b0, 4'd0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, 4'd2, 32'h80000000, 32'h1, 1'b0, 1'b0);
    repeat (5) cycle(1'b1, 4'd1, 32'h1, 32'h1, 1'b0, 1'b0);
`ifdef ALU_STICKY_OFLOW_EN
    chk("sticky_hold", 1, 35'(st[1]), 35'd1);
`else
    chk("sticky_off", 1, 35'(st[1]), 35'd0);
`endif
    cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1);
    chk("sticky_clr", 1, 35'(st[1]), 35'd0);
    cycle(1'b1, 4'd1, 32'h3, 32'h4, 1'b0, 1'b0);
    cycle(1'b1, 4'd2, 32'h9, 32'h1, 1'b0, 1'b0);
    cycle(1'b1, 4'd1, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b0);
    repeat (4) begin
      cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b0);
      chk("drop_p3", 2, 35'(ov[2]), 35'd0);
    end
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 4'($urandom_range(0, 15)), rnd(), rnd(), 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), rnd(), rnd(),
            $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
    repeat (4) cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
